// File: rtl/otp_byte_fifo.sv
// First-word-fall-through byte FIFO that captures the foo otp bus.
// It provides valid/ready handshakes on both sides, an occupancy count and a sticky back-pressure flag.
module otp_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:WIDTH-1] inp,
  input  logic             inp_valid,
  output logic             inp_ready,
  output logic [0:WIDTH-1] otp,
  output logic             otp_valid,
  input  logic             otp_ready,
  output logic [AW:0]      count,
  output logic             stall,
  input  logic             clr_stall
);

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  logic [0:WIDTH-1] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             r_stall;

  logic w_push;
  logic w_pop;
  logic w_stallSet;

  // Flags depend only on registered occupancy, so there is no ready-through path.
  assign inp_ready  = (r_count != LP_FULL);
  assign otp_valid  = (r_count != '0);
  assign w_push     = inp_valid && inp_ready;
  assign w_pop      = otp_valid && otp_ready;
  assign w_stallSet = inp_valid && !inp_ready;

  assign otp   = otp_valid ? r_mem[r_rdPtr] : '0;
  assign count = r_count;
  assign stall = r_stall;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= inp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

  // A new back-pressure event takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= 1'b0;
    end else if (w_stallSet) begin
      r_stall <= 1'b1;
    end else if (clr_stall) begin
      r_stall <= 1'b0;
    end
  end

endmodule

// File: tb/tb_otp_byte_fifo.sv
// Table-driven self-checking bench for otp_byte_fifo with a queue scoreboard of pushed bytes.
module tb_otp_byte_fifo;

  typedef struct {
    logic       inValid;
    logic [7:0] data;
    logic       outReady;
    logic       clr;
    int         expCount;
    logic       expInReady;
    logic       expOutValid;
    logic       expStall;
  } vecT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:7] inp = '0;
  logic       inp_valid = 1'b0;
  logic       inp_ready;
  logic [0:7] otp;
  logic       otp_valid;
  logic       otp_ready = 1'b0;
  logic [2:0] count;
  logic       stall;
  logic       clr_stall = 1'b0;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] model [$];
  vecT vecs [$];

  otp_byte_fifo #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .inp(inp), .inp_valid(inp_valid), .inp_ready(inp_ready),
    .otp(otp), .otp_valid(otp_valid), .otp_ready(otp_ready),
    .count(count), .stall(stall), .clr_stall(clr_stall)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic v, input logic [7:0] d, input logic r, input logic c,
                        input int ec, input logic eir, input logic eov, input logic est);
    vecT t;
    t.inValid = v; t.data = d; t.outReady = r; t.clr = c;
    t.expCount = ec; t.expInReady = eir; t.expOutValid = eov; t.expStall = est;
    vecs.push_back(t);
  endtask

  task automatic checkHead(input string name);
    if (model.size() > 0) checkOutput(name, 32'(otp), 32'(model[0]));
    else checkOutput(name, 32'(otp), 32'h0);
  endtask

  // Drive one cycle of stimulus at the falling edge, update the scoreboard, check after the rising edge.
  task automatic applyStimulus(input vecT v, input int idx);
    logic doPop, doPush;
    logic [7:0] exp;
    @(negedge clk);
    inp_valid = v.inValid;
    inp       = v.data;
    otp_ready = v.outReady;
    clr_stall = v.clr;
    #1;
    doPop  = v.outReady && (model.size() > 0);
    doPush = v.inValid && (model.size() < 4);
    if (doPop) begin
      exp = model.pop_front();
      checkOutput($sformatf("popData[%0d]", idx), 32'(otp), 32'(exp));
    end
    if (doPush) model.push_back(v.data);
    @(posedge clk);
    #1;
    checkOutput($sformatf("count[%0d]", idx), 32'(count), 32'(v.expCount));
    checkOutput($sformatf("inReady[%0d]", idx), 32'(inp_ready), 32'(v.expInReady));
    checkOutput($sformatf("outValid[%0d]", idx), 32'(otp_valid), 32'(v.expOutValid));
    checkOutput($sformatf("stall[%0d]", idx), 32'(stall), 32'(v.expStall));
    checkHead($sformatf("head[%0d]", idx));
  endtask

  initial begin
    vecT v;
    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rstOutValid", 32'(otp_valid), 32'h0);
    checkOutput("rstOtp", 32'(otp), 32'h0);
    checkOutput("rstInReady", 32'(inp_ready), 32'h1);
    checkOutput("rstCount", 32'(count), 32'h0);
    checkOutput("rstStall", 32'(stall), 32'h0);

    // Fill to full, then drain in order, then pop while empty
    addVec(1, 8'hA5, 0, 0, 1, 1, 1, 0);
    addVec(1, 8'h5A, 0, 0, 2, 1, 1, 0);
    addVec(1, 8'h0F, 0, 0, 3, 1, 1, 0);
    addVec(1, 8'hF0, 0, 0, 4, 0, 1, 0);
    addVec(0, 8'h00, 1, 0, 3, 1, 1, 0);
    addVec(0, 8'h00, 1, 0, 2, 1, 1, 0);
    addVec(0, 8'h00, 1, 0, 1, 1, 1, 0);
    addVec(0, 8'h00, 1, 0, 0, 1, 0, 0);
    addVec(0, 8'h00, 1, 0, 0, 1, 0, 0);
    // Concurrent push/pop holding count at 2 across several pointer wraps
    addVec(1, 8'h01, 0, 0, 1, 1, 1, 0);
    addVec(1, 8'h02, 0, 0, 2, 1, 1, 0);
    for (int i = 3; i <= 10; i++) addVec(1, 8'(i), 1, 0, 2, 1, 1, 0);
    addVec(0, 8'h00, 1, 0, 1, 1, 1, 0);
    addVec(0, 8'h00, 1, 0, 0, 1, 0, 0);
    // Sticky stall: back-pressure, clear blocked while still pushing into full, then real clear
    addVec(1, 8'h11, 0, 0, 1, 1, 1, 0);
    addVec(1, 8'h22, 0, 0, 2, 1, 1, 0);
    addVec(1, 8'h33, 0, 0, 3, 1, 1, 0);
    addVec(1, 8'h44, 0, 0, 4, 0, 1, 0);
    for (int i = 0; i < 3; i++) addVec(1, 8'h55, 0, 0, 4, 0, 1, 1);
    addVec(0, 8'h00, 0, 0, 4, 0, 1, 1);
    addVec(1, 8'h55, 0, 1, 4, 0, 1, 1);
    addVec(0, 8'h00, 1, 0, 3, 1, 1, 1);
    addVec(0, 8'h00, 0, 1, 3, 1, 1, 0);

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Async reset between edges with three bytes queued
    @(negedge clk);
    inp_valid = 1'b0; otp_ready = 1'b0; clr_stall = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncCount", 32'(count), 32'h0);
    checkOutput("asyncOutValid", 32'(otp_valid), 32'h0);
    checkOutput("asyncOtp", 32'(otp), 32'h0);
    checkOutput("asyncInReady", 32'(inp_ready), 32'h1);
    model.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    v.inValid = 1; v.data = 8'h3C; v.outReady = 0; v.clr = 0;
    v.expCount = 1; v.expInReady = 1; v.expOutValid = 1; v.expStall = 0;
    applyStimulus(v, 100);
    checkOutput("postRstOtp", 32'(otp), 32'h3C);
    v.inValid = 0; v.data = 8'h00; v.outReady = 1;
    v.expCount = 0; v.expOutValid = 0;
    applyStimulus(v, 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/otp_byte_fifo.md
Name: otp_byte_fifo

Overview:
- Capture stage directly downstream of the foo buffer array. It takes the 8-bit otp bus from a foo instance on its inp port and buffers those bytes in a small first-word-fall-through FIFO.
- Upstream and downstream sides both use a valid/ready handshake.
- Provides an occupancy count and a sticky stall flag so the top level can detect back-pressure on the buffer path.

Parameters:
- WIDTH, 8, data width in bits; matches the foo bus, bit 0 is the MSB ([0:WIDTH-1] ordering).
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- inp  input  WIDTH ([0:WIDTH-1])  write data, driven from foo otp.
- inp_valid  input  1  write request; inp is valid while high.
- inp_ready  output  1  FIFO can accept a byte this cycle.
- otp  output  WIDTH ([0:WIDTH-1])  head-of-queue data.
- otp_valid  output  1  otp holds a valid byte.
- otp_ready  input  1  consumer accepts otp this cycle.
- count  output  AW+1  current occupancy, 0..DEPTH.
- stall  output  1  sticky; set when the source was back-pressured.
- clr_stall  input  1  synchronous clear for stall.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; stall goes to 0.
  - Resulting outputs: otp_valid=0, inp_ready=1, otp=0.
  - Memory contents are not reset.
- Push: when inp_valid && inp_ready at a rising edge, write inp to mem[wr_ptr], then increment wr_ptr modulo DEPTH.
- Pop: when otp_valid && otp_ready at a rising edge, increment rd_ptr modulo DEPTH.
- count:
  - +1 on push only; -1 on pop only.
  - Unchanged on push+pop in the same cycle, or on neither.
- Output flags, decoded combinationally from count:
  - inp_ready = (count != DEPTH).
  - otp_valid = (count != 0).
- otp:
  - Equals mem[rd_ptr] when otp_valid=1, otherwise all zeros. Never shows stale data.
- Latency: a byte pushed at edge N is visible on otp with otp_valid=1 after edge N. There is no same-cycle bypass, even when empty.
- Full (count==DEPTH): inp_ready=0, so no push. A pop in that cycle takes count to DEPTH-1, and inp_ready rises the following cycle. No combinational ready-through path.
- Empty (count==0): otp_valid=0, so otp_ready is ignored and count never underflows.
- Simultaneous push and pop with 0<count<DEPTH: both pointers advance and count holds. Ordering is preserved.
- Pointer wrap: both pointers wrap from DEPTH-1 to 0 with no gap or duplication. Full and empty are distinguished by count, not pointer compare.
- stall:
  - Set on any rising edge where inp_valid=1 && inp_ready=0.
  - Cleared on an edge with clr_stall=1 and no set condition.
  - Set wins when both occur in the same cycle.
- Reset mid-operation: all queued bytes are discarded. The first push after rst_n deasserts is the first byte seen on otp.
- Protocol (source-side): inp must stay stable while inp_valid=1 && inp_ready=0. The FIFO does not check this.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then high → otp_valid=0, otp=8'h00, inp_ready=1, count=0, stall=0.
- Fill to full: push 8'hA5, 8'h5A, 8'h0F, 8'hF0 with otp_ready=0 → count=4, inp_ready=0; otp=8'hA5 from the cycle after the first push.
- Drain in order: from full, hold otp_ready=1 for 4 cycles → otp sequence A5, 5A, 0F, F0. Then otp_valid=0, otp=8'h00, count=0; inp_ready=1 one cycle after the first pop.
- Concurrent push/pop with wrap: keep count at 2 while pushing 8'h01..8'h0A and popping each cycle → popped sequence is 01..0A in order, both pointers wrap at least twice, count stays 2.
- Stall flag: full FIFO, inp_valid=1 for 3 cycles → stall=1 and stays 1 after inp_valid drops. Assert clr_stall with inp_valid=1 while still full → stall stays 1. Pop one byte, then clr_stall → stall=0.
- Async reset mid-stream: with count=3, pull rst_n low between clock edges → count=0 and otp_valid=0 immediately. After release, push 8'h3C → otp=8'h3C next cycle.
